pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 3-stage pipeline; it drives the IFD->EX pipeline register and the PC.
- Detects load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
- Generates PC enable, IFD/EX register enable, bubble insertion and the stall flag.
- Keeps saturating stall/flush counters for performance monitoring.

Parameters:
FLUSH_CYCLES, 2, consecutive bubble cycles after a taken branch (range 1..15; covers synchronous imem latency)
MEM_TIMEOUT, 64, cycles in MEM_WAIT before mem_timeout is raised (range 1..255)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
ifd_rs1_addr  in  5  rs1 of the instruction in IFD
ifd_rs2_addr  in  5  rs2 of the instruction in IFD
ifd_uses_rs1  in  1  IFD instruction reads rs1
ifd_uses_rs2  in  1  IFD instruction reads rs2
ex_valid  in  1  EX holds a real instruction (not a bubble)
ex_rd_addr  in  5  destination register of the EX instruction
ex_is_load  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
mem_req  in  1  EX is accessing data memory this cycle
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
ifd_ex_en  out  1  IFD/EX register load enable
ifd_ex_bubble  out  1  load a NOP (32'h00000013) into IFD/EX instead of the IFD instruction
stall  out  1  equals !pc_en; drives the register's stall input
mem_timeout  out  1  sticky error flag
state_dbg  out  2  current FSM state encoding
stall_cnt  out  CNT_W  cycles with stall=1, saturating
flush_cnt  out  CNT_W  cycles with bubble asserted by branch, saturating

Behaviour:
- Reset is asynchronous. While rst=1:
  - state=RUN; all counters=0; mem_timeout=0.
  - Outputs forced to pc_en=0, ifd_ex_en=1, ifd_ex_bubble=1 (pipeline fills with NOPs).
- FSM states: RUN=0, MEM_WAIT=1, FLUSH=2. Encoding 3 is unused; if reached, the next state is RUN.
- Outputs are combinational from state and inputs (Mealy). Zero latency: a hazard is acted on in the same cycle it is detected.
- Load-use hazard = ex_valid & ex_is_load & (ex_rd_addr!=0) & ((ifd_uses_rs1 & ifd_rs1_addr==ex_rd_addr) | (ifd_uses_rs2 & ifd_rs2_addr==ex_rd_addr)).
- RUN, priority mem > branch > load-use:
  - ex_valid & mem_req & !mem_ready: pc_en=0, ifd_ex_en=0, bubble=0; next MEM_WAIT; timeout counter loaded with 1.
  - else ex_valid & ex_branch_taken: pc_en=1, ifd_ex_en=1, bubble=1. If FLUSH_CYCLES>1, next FLUSH with remaining=FLUSH_CYCLES-1; otherwise stay in RUN.
  - else load-use: pc_en=0, ifd_ex_en=1, bubble=1; stay in RUN. The hazard clears next cycle because the bubble now occupies EX.
  - else: pc_en=1, ifd_ex_en=1, bubble=0.
- MEM_WAIT:
  - While mem_ready=0: pc_en=0, ifd_ex_en=0, bubble=0. EX is frozen, so its branch/hazard inputs stay stable.
  - The timeout counter increments, saturating at MEM_TIMEOUT. On reaching MEM_TIMEOUT, mem_timeout sets and holds until rst; the FSM keeps waiting.
  - mem_ready=1: same-cycle outputs as RUN with the mem condition treated as false; branch and load-use priority applies. Next state follows the RUN rules (RUN or FLUSH).
- FLUSH:
  - pc_en=1, ifd_ex_en=1, bubble=1; remaining decrements each cycle; at remaining==1 next state is RUN.
  - Inputs are ignored while in FLUSH, because EX holds only bubbles.
- stall_cnt increments every cycle stall=1 (not during rst) and saturates at all-ones.
- flush_cnt increments every cycle bubble is caused by a branch or by FLUSH, and saturates.
- ex_rd_addr==0 never creates a hazard.
- mem_req with mem_ready=1 in the same cycle causes no stall.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum (RUN/MEM_WAIT/FLUSH);
  - NOP_INSTR=32'h00000013;
  - REG_ZERO=5'd0;
  - shared counter-saturation function.
- One natural sub-module: hazard_detect, a purely combinational load-use comparator. The FSM, counters and timeout stay in the top module.

Test Plan:
- Load-use: EX load rd=5, IFD uses rs1=5 -> one cycle pc_en=0, bubble=1, stall=1; next cycle pc_en=1; stall_cnt=1.
- Load with rd=0, IFD rs1=0 -> no stall; rd=7, IFD rs2=7 with ifd_uses_rs2=0 -> no stall.
- Taken branch, FLUSH_CYCLES=2 -> bubble=1 for exactly 2 cycles with pc_en=1 (RUN then FLUSH), back to RUN; flush_cnt=2.
- mem_req held with mem_ready=0 for 3 cycles, then 1 -> pc_en=0 and ifd_ex_en=0 for 3 cycles, then released; state_dbg shows 1,1,1 then 0.
- MEM_WAIT with ex_branch_taken=1 and mem_ready rising on cycle 4 -> freeze for 3 cycles, bubble on the release cycle, then FLUSH.
- mem_ready held 0 for 70 cycles, MEM_TIMEOUT=64 -> mem_timeout=1 from the 64th wait cycle and stays set. Assert rst mid-wait -> state RUN, counters 0, flag cleared asynchronously.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the 3-stage pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [31:0]        NOP_INSTR = 32'h0000_0013;
  localparam logic [REG_AW-1:0]  REG_ZERO  = 5'd0;

  // Increment that sticks at max; callers cast to/from their own width (<= 32 bits).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator between the EX load and the IFD source operands.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic              uses_rs1_i,
  input  logic              uses_rs2_i,
  output logic              load_use_o
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match  = uses_rs1_i & (rs1_addr_i == ex_rd_addr_i);
  assign rs2_match  = uses_rs2_i & (rs2_addr_i == ex_rd_addr_i);
  // x0 is hardwired to zero, so a load targeting it never produces a dependency.
  assign load_use_o = ex_valid_i & ex_is_load_i & (ex_rd_addr_i != REG_ZERO) &
                      (rs1_match | rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the IFD->EX register and PC: load-use stalls,
// branch flushes, data-memory waits with timeout, and saturating perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ifd_rs1_addr_i,
  input  logic [REG_AW-1:0] ifd_rs2_addr_i,
  input  logic              ifd_uses_rs1_i,
  input  logic              ifd_uses_rs2_i,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  input  logic              ex_is_load_i,
  input  logic              ex_branch_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  output logic              pc_en_o,
  output logic              ifd_ex_en_o,
  output logic              ifd_ex_bubble_o,
  output logic              stall_o,
  output logic              mem_timeout_o,
  output logic [1:0]        state_dbg_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int unsigned TMO_W = 8;
  localparam int unsigned REM_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic mem_stall;
  logic branch;
  logic resolve;
  logic pc_en_c;
  logic ifd_ex_en_c;
  logic bubble_c;
  logic flush_bubble_c;

  hazard_detect u_hazard_detect (
    .ex_valid_i   (ex_valid_i),
    .ex_is_load_i (ex_is_load_i),
    .ex_rd_addr_i (ex_rd_addr_i),
    .rs1_addr_i   (ifd_rs1_addr_i),
    .rs2_addr_i   (ifd_rs2_addr_i),
    .uses_rs1_i   (ifd_uses_rs1_i),
    .uses_rs2_i   (ifd_uses_rs2_i),
    .load_use_o   (load_use)
  );

  assign mem_stall = ex_valid_i & mem_req_i & ~mem_ready_i;
  assign branch    = ex_valid_i & ex_branch_taken_i;

  // Next-state and Mealy outputs; RUN and a released MEM_WAIT share the branch/load-use rules.
  always_comb begin
    state_d        = state_q;
    tmo_d          = tmo_q;
    rem_d          = rem_q;
    resolve        = 1'b0;
    pc_en_c        = 1'b1;
    ifd_ex_en_c    = 1'b1;
    bubble_c       = 1'b0;
    flush_bubble_c = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          pc_en_c     = 1'b0;
          ifd_ex_en_c = 1'b0;
          state_d     = MEM_WAIT;
          tmo_d       = TMO_W'(1);
        end else begin
          resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready_i) begin
          pc_en_c     = 1'b0;
          ifd_ex_en_c = 1'b0;
          tmo_d       = TMO_W'(sat_inc(32'(tmo_q), MEM_TIMEOUT));
        end else begin
          resolve = 1'b1;
        end
      end
      FLUSH: begin
        bubble_c       = 1'b1;
        flush_bubble_c = 1'b1;
        rem_d          = rem_q - REM_W'(1);
        if (rem_q <= REM_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (resolve) begin
      state_d = RUN;
      if (branch) begin
        bubble_c       = 1'b1;
        flush_bubble_c = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          rem_d   = REM_W'(FLUSH_CYCLES - 1);
        end
      end else if (load_use) begin
        pc_en_c  = 1'b0;
        bubble_c = 1'b1;
      end
    end

    // Reset fills the pipeline with NOPs while holding the PC.
    if (rst) begin
      pc_en_c        = 1'b0;
      ifd_ex_en_c    = 1'b1;
      bubble_c       = 1'b1;
      flush_bubble_c = 1'b0;
    end
  end

  always_comb begin
    timeout_d   = timeout_q | ((state_d == MEM_WAIT) && (tmo_d == TMO_W'(MEM_TIMEOUT)));
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en_c)       stall_cnt_d = CNT_W'(sat_inc(32'(stall_cnt_q), 32'(CNT_MAX)));
    if (flush_bubble_c) flush_cnt_d = CNT_W'(sat_inc(32'(flush_cnt_q), 32'(CNT_MAX)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      tmo_q       <= '0;
      rem_q       <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      rem_q       <= rem_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_en_o         = pc_en_c;
  assign ifd_ex_en_o     = ifd_ex_en_c;
  assign ifd_ex_bubble_o = bubble_c;
  assign stall_o         = ~pc_en_c;
  assign mem_timeout_o   = timeout_q;
  assign state_dbg_o     = state_q;
  assign stall_cnt_o     = stall_cnt_q;
  assign flush_cnt_o     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a behavioural model predicts each cycle's outputs.
module tb_pipeline_hazard_ctrl;

  localparam int FC = 2;
  localparam int MT = 64;

  typedef struct {
    logic       v, ld, br, req, rdy, u1, u2;
    logic [4:0] rd, rs1, rs2;
  } stim_t;

  typedef struct {
    logic        pc, en, bub, to;
    logic [1:0]  st;
    logic [15:0] sc, fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        u1 = 0, u2 = 0, v = 0, ld = 0, br = 0, req = 0, rdy = 0;
  logic        pc_en, ifd_ex_en, bubble, stall, mem_to;
  logic [1:0]  state_dbg;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  exp_t sb_q[$];

  int          m_state = 0, m_wait = 0, m_left = 0;
  logic        m_to = 0;
  logic [15:0] m_sc = 0, m_fc = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .ifd_rs1_addr_i    (rs1),
    .ifd_rs2_addr_i    (rs2),
    .ifd_uses_rs1_i    (u1),
    .ifd_uses_rs2_i    (u2),
    .ex_valid_i        (v),
    .ex_rd_addr_i      (rd),
    .ex_is_load_i      (ld),
    .ex_branch_taken_i (br),
    .mem_req_i         (req),
    .mem_ready_i       (rdy),
    .pc_en_o           (pc_en),
    .ifd_ex_en_o       (ifd_ex_en),
    .ifd_ex_bubble_o   (bubble),
    .stall_o           (stall),
    .mem_timeout_o     (mem_to),
    .state_dbg_o       (state_dbg),
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic sv, input logic sld, input int srd,
                               input int s1, input logic su1, input int s2, input logic su2,
                               input logic sbr, input logic sreq, input logic srdy);
    stim_t s;
    s.v = sv; s.ld = sld; s.rd = 5'(srd); s.rs1 = 5'(s1); s.u1 = su1;
    s.rs2 = 5'(s2); s.u2 = su2; s.br = sbr; s.req = sreq; s.rdy = srdy;
    return s;
  endfunction

  // Reference behaviour: report pre-edge outputs, then advance the model one cycle.
  task automatic model_step(input stim_t s, output exp_t e);
    logic lu, mem, tk, fl;
    e.st = 2'(m_state); e.to = m_to; e.sc = m_sc; e.fc = m_fc;
    fl  = 1'b0;
    lu  = s.v && s.ld && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    mem = s.v && s.req && !s.rdy;
    tk  = s.v && s.br;
    if (m_state == 2) begin
      e.pc = 1; e.en = 1; e.bub = 1; fl = 1;
      m_left--;
      if (m_left == 0) m_state = 0;
    end else if ((m_state == 0 && mem) || (m_state == 1 && !s.rdy)) begin
      e.pc = 0; e.en = 0; e.bub = 0;
      if (m_state == 0) begin
        m_state = 1; m_wait = 1;
      end else if (m_wait < MT) begin
        m_wait++;
      end
      if (m_wait == MT) m_to = 1;
    end else begin
      m_state = 0;
      if (tk) begin
        e.pc = 1; e.en = 1; e.bub = 1; fl = 1;
        if (FC > 1) begin m_state = 2; m_left = FC - 1; end
      end else if (lu) begin
        e.pc = 0; e.en = 1; e.bub = 1;
      end else begin
        e.pc = 1; e.en = 1; e.bub = 0;
      end
    end
    if (!e.pc && m_sc != 16'hFFFF) m_sc++;
    if (fl && m_fc != 16'hFFFF) m_fc++;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("pc_en",     32'(pc_en),     32'(e.pc));
    check("ifd_ex_en", 32'(ifd_ex_en), 32'(e.en));
    check("bubble",    32'(bubble),    32'(e.bub));
    check("stall",     32'(stall),     32'(!e.pc));
    check("state_dbg", 32'(state_dbg), 32'(e.st));
    check("mem_to",    32'(mem_to),    32'(e.to));
    check("stall_cnt", 32'(stall_cnt), 32'(e.sc));
    check("flush_cnt", 32'(flush_cnt), 32'(e.fc));
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(negedge clk);
    v = s.v; ld = s.ld; rd = s.rd; rs1 = s.rs1; u1 = s.u1;
    rs2 = s.rs2; u2 = s.u2; br = s.br; req = s.req; rdy = s.rdy;
    model_step(s, e);
    sb_q.push_back(e);
    #1;
    compare_out();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc_en"},  32'(pc_en),     32'd0);
    check({tag, "_en"},     32'(ifd_ex_en), 32'd1);
    check({tag, "_bubble"}, 32'(bubble),    32'd1);
    check({tag, "_stall"},  32'(stall),     32'd1);
    check({tag, "_state"},  32'(state_dbg), 32'd0);
    check({tag, "_to"},     32'(mem_to),    32'd0);
    check({tag, "_scnt"},   32'(stall_cnt), 32'd0);
    check({tag, "_fcnt"},   32'(flush_cnt), 32'd0);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_state = 0; m_wait = 0; m_left = 0; m_to = 0; m_sc = 0; m_fc = 0;
  endtask

  stim_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check_reset_state("rst0");
    @(negedge clk);
    rst = 1'b0;

    repeat (2) drive(idle);

    // Load-use on rs1, then the bubble reaches EX
    drive(mk(1, 1, 5, 5, 1, 0, 0, 0, 0, 0));
    drive(idle);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Non-hazards: rd=0, and an unused rs2 match
    drive(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    drive(mk(1, 1, 7, 0, 0, 7, 0, 0, 0, 0));
    drive(mk(1, 1, 7, 0, 0, 7, 1, 0, 0, 0));
    drive(idle);
    // Memory access completing immediately
    drive(mk(1, 0, 3, 0, 0, 0, 0, 0, 1, 1));

    // Taken branch followed by the flush bubble
    drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    drive(idle);
    drive(idle);
    check("br_flush_cnt", 32'(flush_cnt), 32'd2);

    // Memory wait for 3 cycles, released on the 4th
    repeat (3) drive(mk(1, 0, 2, 0, 0, 0, 0, 0, 1, 0));
    drive(mk(1, 0, 2, 0, 0, 0, 0, 0, 1, 1));
    drive(idle);

    // Memory wait with a pending taken branch
    repeat (3) drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    drive(idle);
    drive(idle);

    // Long wait crossing the timeout, then asynchronous reset mid-wait
    repeat (70) drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    check("to_set", 32'(mem_to), 32'd1);
    check("to_state", 32'(state_dbg), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_state("rst_mid");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    v = 0; req = 0; rdy = 0; br = 0; ld = 0;

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive(mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) != 0));
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
